// File: rtl/shift_arb_pkg.sv
// Shared definitions for the shift burst arbiter.
//   state_t   : FSM encoding (IDLE / RUN / DONE)
//   count_lsb : bit offset of requester idx's burst count inside the packed
//               count_in bus (idx * width)
package shift_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned count_lsb(input int unsigned idx,
                                              input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/shift_burst_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
// Searches req starting at ptr and wrapping modulo NREQ; the first set bit
// found wins.
//   req : request vector, one bit per requester
//   ptr : index with highest priority this round (must be < NREQ)
//   any : at least one request is set
//   idx : index of the winning requester (0 when any is low)
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  idx
);

    // cand[k] is the requester examined k-th in this round: (ptr + k) mod NREQ.
    logic [IDW-1:0] cand [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand[gi] = IDW'((int'(ptr) + gi) % NREQ);
        end
    endgenerate

    // Walk from the lowest priority candidate up so that the highest priority
    // hit is the last assignment and therefore wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                any = 1'b1;
                idx = cand[k];
            end
        end
    end

endmodule

// File: rtl/shift_burst_arbiter.sv
// Burst arbiter for a shared shifter enable.
// A round-robin winner is granted the shifter for count_in[winner] non-held
// cycles, then a one-cycle done pulse reports which requester finished and
// whether it ended early because its request was withdrawn.
//   clk      : clock
//   reset    : asynchronous, active-high reset
//   req      : per-requester level request, held until done
//   count_in : packed burst lengths, requester i at [i*WIDTH +: WIDTH]
//   hold     : shifter stall; freezes the running burst
//   grant    : one-hot owner while a burst runs, zero otherwise
//   shift_en : shifter enable
//   busy     : a burst is in progress (RUN or DONE)
//   done     : one-cycle completion pulse
//   done_id  : finished requester index, valid with done
//   aborted  : with done, the burst ended because req dropped
module shift_burst_arbiter
    import shift_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] count_in,
    input  logic                  hold,
    output logic [NREQ-1:0]       grant,
    output logic                  shift_en,
    output logic                  busy,
    output logic                  done,
    output logic [IDW-1:0]        done_id,
    output logic                  aborted
);

    state_t           state_reg,   state_next;
    logic [WIDTH-1:0] count_reg,   count_next;
    logic [IDW-1:0]   owner_reg,   owner_next;
    logic [IDW-1:0]   ptr_reg,     ptr_next;
    logic             aborted_reg, aborted_next;

    logic             pick_any;
    logic [IDW-1:0]   pick_idx;
    logic [WIDTH-1:0] count_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_count
            localparam int unsigned LSB = count_lsb(gi, WIDTH);
            assign count_arr[gi] = count_in[LSB +: WIDTH];
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req (req),
        .ptr (ptr_reg),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            owner_reg   <= '0;
            ptr_reg     <= '0;
            aborted_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            owner_reg   <= owner_next;
            ptr_reg     <= ptr_next;
            aborted_reg <= aborted_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        owner_next   = owner_reg;
        ptr_next     = ptr_reg;
        aborted_next = aborted_reg;

        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    owner_next   = pick_idx;
                    count_next   = count_arr[pick_idx];
                    aborted_next = 1'b0;
                    // A zero-length burst skips RUN and completes normally.
                    state_next   = (count_arr[pick_idx] != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // A withdrawn request wins over a simultaneous final shift.
                if (!req[owner_reg]) begin
                    state_next   = DONE;
                    aborted_next = 1'b1;
                end else if (!hold) begin
                    count_next = count_reg - WIDTH'(1);
                    if (count_reg == WIDTH'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next   = IDLE;
                aborted_next = 1'b0;
                ptr_next     = (owner_reg == IDW'(NREQ - 1)) ? '0 : owner_reg + IDW'(1);
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
            assign grant[gi] = (state_reg == RUN) && (owner_reg == IDW'(gi));
        end
    endgenerate

    assign shift_en = (state_reg == RUN) && !hold;
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign done_id  = done ? owner_reg : '0;
    assign aborted  = aborted_reg;

endmodule
